// File: rtl/systolic_pkg.sv
// systolic_pkg: shared tile-engine types, drain-length rule and lane-packing helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } tileState_e;

  // SIMD mode that splits every element into two independent half-width lanes.
  localparam logic [1:0] SimdDual = 2'b01;

  // Cycles needed after the last beat for the wavefront to cross the array and settle.
  function automatic int drainLen(input int h, input int w, input int peLatency);
    return h + w + peLatency;
  endfunction

  // LSB of lane `lane` in a packed vector of `width`-bit elements.
  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

  // LSB of element (row, col) in a row-major packed matrix with `cols` columns.
  function automatic int elemLsb(input int row, input int col, input int cols, input int width);
    return (row * cols + col) * width;
  endfunction

endpackage

// File: rtl/systolic_array.sv
// systolic_array: output-stationary MAC grid; A flows east, B flows south, results latch on in_done_flag.
// The floating-point PE variant is not modelled here; the float parameters are kept so the
// parameter list stays drop-in compatible and the integer datapath is always used.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int EXP_BITS   = 5,
  parameter int FRAC_BITS  = 10,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ARR_HEIGHT*WIDTH-1:0]         in_a,
  input  logic [ARR_WIDTH*WIDTH-1:0]          in_b,
  input  logic                                in_done_flag,
  input  logic [1:0]                          SIMD_control,
  output logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] out_c
);

  localparam int Half = WIDTH / 2;

  logic [31:0] unusedFloatCfg;
  assign unusedFloatCfg = 32'(IS_FLOAT) ^ 32'(EXP_BITS) ^ 32'(FRAC_BITS);

  logic [WIDTH-1:0] aPipe_q [ARR_HEIGHT][ARR_WIDTH];
  logic [WIDTH-1:0] bPipe_q [ARR_HEIGHT][ARR_WIDTH];
  logic [WIDTH-1:0] acc_q   [ARR_HEIGHT][ARR_WIDTH];
  logic [WIDTH-1:0] aIn     [ARR_HEIGHT][ARR_WIDTH];
  logic [WIDTH-1:0] bIn     [ARR_HEIGHT][ARR_WIDTH];
  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] outC_q;

  function automatic logic [WIDTH-1:0] laneMul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [1:0] mode);
    logic [Half-1:0]       lo;
    logic [WIDTH-Half-1:0] hi;
    lo = x[Half-1:0] * y[Half-1:0];
    hi = x[WIDTH-1:Half] * y[WIDTH-1:Half];
    if (mode == SimdDual) return {hi, lo};
    return x * y;
  endfunction

  function automatic logic [WIDTH-1:0] laneAdd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [1:0] mode);
    logic [Half-1:0]       lo;
    logic [WIDTH-Half-1:0] hi;
    lo = x[Half-1:0] + y[Half-1:0];
    hi = x[WIDTH-1:Half] + y[WIDTH-1:Half];
    if (mode == SimdDual) return {hi, lo};
    return x + y;
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < ARR_HEIGHT; gi++) begin : gRow
      for (gj = 0; gj < ARR_WIDTH; gj++) begin : gCol
        if (gj == 0) begin : gWest
          assign aIn[gi][gj] = in_a[laneLsb(gi, WIDTH) +: WIDTH];
        end else begin : gEast
          assign aIn[gi][gj] = aPipe_q[gi][gj-1];
        end
        if (gi == 0) begin : gNorth
          assign bIn[gi][gj] = in_b[laneLsb(gj, WIDTH) +: WIDTH];
        end else begin : gSouth
          assign bIn[gi][gj] = bPipe_q[gi-1][gj];
        end
      end
    end
  endgenerate

  // Every PE forwards its operands one hop and accumulates their product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARR_HEIGHT; i++) begin
        for (int j = 0; j < ARR_WIDTH; j++) begin
          aPipe_q[i][j] <= '0;
          bPipe_q[i][j] <= '0;
          acc_q[i][j]   <= '0;
        end
      end
    end else begin
      for (int i = 0; i < ARR_HEIGHT; i++) begin
        for (int j = 0; j < ARR_WIDTH; j++) begin
          aPipe_q[i][j] <= aIn[i][j];
          bPipe_q[i][j] <= bIn[i][j];
          acc_q[i][j]   <= laneAdd(acc_q[i][j], laneMul(aIn[i][j], bIn[i][j], SIMD_control), SIMD_control);
        end
      end
    end
  end

  // Snapshot the accumulators into the result matrix when the done flag arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outC_q <= '0;
    end else if (in_done_flag) begin
      for (int i = 0; i < ARR_HEIGHT; i++) begin
        for (int j = 0; j < ARR_WIDTH; j++) begin
          outC_q[elemLsb(i, j, ARR_WIDTH, WIDTH) +: WIDTH] <= acc_q[i][j];
        end
      end
    end
  end

  assign out_c = outC_q;

endmodule

// File: rtl/systolic_tile_engine_skew.sv
// skew_delay_line: per-lane registered shift chain used to build the diagonal input skew.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; the oldest stage is the lane output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: handshaked per-tile control, input skew and result register around systolic_array.
module systolic_tile_engine
  import systolic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int EXP_BITS   = 5,
  parameter int FRAC_BITS  = 10,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int PE_LATENCY = 4,
  parameter int K_BITS     = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [K_BITS-1:0]                     k_len,
  input  logic [1:0]                            SIMD_control,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARR_HEIGHT*WIDTH-1:0]           in_a,
  input  logic [ARR_WIDTH*WIDTH-1:0]            in_b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] out_c,
  output logic                                  busy
);

  localparam int DrainCycles = drainLen(ARR_HEIGHT, ARR_WIDTH, PE_LATENCY);
  localparam int DoneAt      = ARR_HEIGHT + ARR_WIDTH;
  localparam int DcBits      = $clog2(DrainCycles + 1);
  localparam int CBits       = ARR_HEIGHT * ARR_WIDTH * WIDTH;

  tileState_e          state_q, state_d;
  logic [K_BITS-1:0]   kLen_q, kLen_d;
  logic [K_BITS-1:0]   beatCnt_q, beatCnt_d;
  logic [DcBits-1:0]   drainCnt_q, drainCnt_d;
  logic [1:0]          simd_q, simd_d;
  logic                clear_q, clear_d;
  logic                inReady_q, inReady_d;
  logic                outValid_q, outValid_d;
  logic                busy_q, busy_d;
  logic [CBits-1:0]    outC_q, outC_d;

  logic                        accept;
  logic                        doneFlag;
  logic                        arrReset;
  logic [ARR_HEIGHT*WIDTH-1:0] pushA, skewA;
  logic [ARR_WIDTH*WIDTH-1:0]  pushB, skewB;
  logic [CBits-1:0]            arrOutC;

  assign accept   = in_valid & inReady_q;
  assign pushA    = accept ? in_a : '0;
  assign pushB    = accept ? in_b : '0;
  assign doneFlag = (state_q == DRAIN) && (drainCnt_q == DcBits'(DoneAt));
  assign arrReset = reset | clear_q;

  genvar gi;
  generate
    for (gi = 0; gi < ARR_HEIGHT; gi++) begin : gSkewA
      skew_delay_line #(.WIDTH(WIDTH), .DEPTH(gi + 1)) uSkew (
        .clk   (clk),
        .reset (reset),
        .din_i (pushA[laneLsb(gi, WIDTH) +: WIDTH]),
        .dout_o(skewA[laneLsb(gi, WIDTH) +: WIDTH])
      );
    end
    for (gi = 0; gi < ARR_WIDTH; gi++) begin : gSkewB
      skew_delay_line #(.WIDTH(WIDTH), .DEPTH(gi + 1)) uSkew (
        .clk   (clk),
        .reset (reset),
        .din_i (pushB[laneLsb(gi, WIDTH) +: WIDTH]),
        .dout_o(skewB[laneLsb(gi, WIDTH) +: WIDTH])
      );
    end
  endgenerate

  systolic_array #(
    .WIDTH     (WIDTH),
    .IS_FLOAT  (IS_FLOAT),
    .EXP_BITS  (EXP_BITS),
    .FRAC_BITS (FRAC_BITS),
    .ARR_HEIGHT(ARR_HEIGHT),
    .ARR_WIDTH (ARR_WIDTH)
  ) uArray (
    .clk         (clk),
    .reset       (arrReset),
    .in_a        (skewA),
    .in_b        (skewB),
    .in_done_flag(doneFlag),
    .SIMD_control(simd_q),
    .out_c       (arrOutC)
  );

  // Next-state decode: tile start, beat counting, drain countdown and result handoff.
  always_comb begin
    state_d    = state_q;
    kLen_d     = kLen_q;
    beatCnt_d  = beatCnt_q;
    drainCnt_d = drainCnt_q;
    simd_d     = simd_q;
    clear_d    = 1'b0;
    outValid_d = outValid_q;
    outC_d     = outC_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kLen_d     = k_len;
          simd_d     = SIMD_control;
          beatCnt_d  = '0;
          drainCnt_d = '0;
          clear_d    = 1'b1;
          state_d    = (k_len == '0) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          beatCnt_d = beatCnt_q + K_BITS'(1);
          if (beatCnt_d == kLen_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drainCnt_q == DcBits'(DrainCycles - 1)) begin
          drainCnt_d = '0;
          outC_d     = arrOutC;
          outValid_d = 1'b1;
          state_d    = HOLD;
        end else begin
          drainCnt_d = drainCnt_q + DcBits'(1);
        end
      end
      HOLD: begin
        if (outValid_q && out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    inReady_d = (state_d == FEED);
    busy_d    = (state_d != IDLE);
  end

  // Tile FSM state and its registered outputs; reset aborts any tile in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kLen_q     <= '0;
      beatCnt_q  <= '0;
      drainCnt_q <= '0;
      simd_q     <= '0;
      clear_q    <= 1'b0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      outC_q     <= '0;
    end else begin
      state_q    <= state_d;
      kLen_q     <= kLen_d;
      beatCnt_q  <= beatCnt_d;
      drainCnt_q <= drainCnt_d;
      simd_q     <= simd_d;
      clear_q    <= clear_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
      busy_q     <= busy_d;
      outC_q     <= outC_d;
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign out_c     = outC_q;

endmodule

// File: tb/tb_systolic_tile_engine.sv
// tb_systolic_tile_engine: directed tile vectors with hand-computed results and latencies.
`timescale 1ns/1ps
module tb_systolic_tile_engine;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int C  = 4;
  localparam int KB = 8;
  localparam int CB = H * C * W;

  // Element j of a row sits at bits j*16, so the lowest hex digit group is column 0.
  localparam logic [63:0] Row1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] Row2 = {16'd8, 16'd6, 16'd4, 16'd2};
  localparam logic [63:0] Row3 = {16'd12, 16'd9, 16'd6, 16'd3};

  typedef struct {
    int            kLen;
    int            aScale;
    bit            bubbles;
    logic [CB-1:0] expC;
    int            expLat;
  } tileVec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [KB-1:0]   k_len;
  logic [1:0]      SIMD_control;
  logic            in_valid;
  logic            in_ready;
  logic [H*W-1:0]  in_a;
  logic [C*W-1:0]  in_b;
  logic            out_valid;
  logic            out_ready;
  logic [CB-1:0]   out_c;
  logic            busy;

  int              vecCount = 0;
  int              missCount = 0;
  int              cycNo = 0;
  int              lat;
  logic [CB-1:0]   got;
  tileVec_t        vecs [7];

  systolic_tile_engine #(
    .WIDTH(W), .IS_FLOAT(0), .EXP_BITS(5), .FRAC_BITS(10),
    .ARR_HEIGHT(H), .ARR_WIDTH(C), .PE_LATENCY(4), .K_BITS(KB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .SIMD_control(SIMD_control),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Count rising edges so latencies can be measured in edges after start.
  always @(posedge clk) cycNo <= cycNo + 1;

  // Hard stop in case a handshake never completes.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 400us");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [H*W-1:0] beatA(input int idx, input int scale);
    logic [H*W-1:0] v;
    v = '0;
    for (int i = 0; i < H; i++) if (i == idx) v[i*W +: W] = W'(scale);
    return v;
  endfunction

  task automatic checkOutput(input string what, input logic [CB-1:0] actual, input logic [CB-1:0] required);
    vecCount++;
    if (actual !== required) begin
      missCount++;
      $display("[TB] FAIL %s: got %h required %h", what, actual, required);
    end
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge where out_valid is first seen.
  task automatic applyStimulus(input tileVec_t v, output int latency, output logic [CB-1:0] result);
    int            sEdge;
    int            beats;
    int            feedIdx;
    int            guard;
    logic [63:0]   bRow;
    bRow = Row1;
    start = 1'b1;
    k_len = KB'(v.kLen);
    SIMD_control = 2'b00;
    @(negedge clk);
    start = 1'b0;
    k_len = '0;
    sEdge = cycNo;
    if (v.kLen > 0) checkOutput("in_ready_after_start", CB'(in_ready), CB'(1));
    beats = 0;
    feedIdx = 0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 300) begin
      in_valid = 1'b0;
      in_a = '1;
      in_b = '1;
      if (in_ready === 1'b1 && beats < v.kLen) begin
        if (!(v.bubbles && (feedIdx % 2 == 0))) begin
          in_valid = 1'b1;
          in_a = beatA(beats, v.aScale);
          in_b = bRow;
          beats++;
        end
        feedIdx++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    latency = (out_valid === 1'b1) ? (cycNo - sEdge + 1) : -1;
    result = out_c;
  endtask

  // Main sequence: reset values, vector table, hold back-pressure, async reset cases.
  initial begin
    vecs[0] = '{4, 1, 1'b0, {Row1, Row1, Row1, Row1}, 17};
    vecs[1] = '{4, 2, 1'b0, {Row2, Row2, Row2, Row2}, 17};
    vecs[2] = '{4, 1, 1'b1, {Row1, Row1, Row1, Row1}, 21};
    vecs[3] = '{0, 1, 1'b0, {CB{1'b0}}, 13};
    vecs[4] = '{2, 1, 1'b0, {64'd0, 64'd0, Row1, Row1}, 15};
    vecs[5] = '{6, 1, 1'b0, {Row1, Row1, Row1, Row1}, 19};
    vecs[6] = '{3, 3, 1'b0, {64'd0, Row3, Row3, Row3}, 16};

    reset = 1'b1;
    start = 1'b0;
    k_len = '0;
    SIMD_control = 2'b00;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #12;
    checkOutput("reset_flags", CB'({in_ready, out_valid, busy}), CB'(0));
    checkOutput("reset_out_c", out_c, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      applyStimulus(vecs[t], lat, got);
      checkOutput($sformatf("vec%0d_latency", t), CB'(lat), CB'(vecs[t].expLat));
      checkOutput($sformatf("vec%0d_out_c", t), got, vecs[t].expC);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_idle_after_accept", t), CB'({out_valid, busy}), CB'(0));
    end

    out_ready = 1'b0;
    applyStimulus(vecs[0], lat, got);
    checkOutput("hold_latency", CB'(lat), CB'(17));
    for (int c = 0; c < 10; c++) begin
      start = 1'b1;
      k_len = 8'd3;
      @(negedge clk);
      checkOutput($sformatf("hold%0d_out_c", c), out_c, vecs[0].expC);
      checkOutput($sformatf("hold%0d_flags", c), CB'({out_valid, busy, in_ready}), CB'(3'b110));
    end
    start = 1'b0;
    k_len = '0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_released", CB'({out_valid, busy}), CB'(0));

    out_ready = 1'b0;
    applyStimulus(vecs[6], lat, got);
    checkOutput("pre_reset_hold_out_c", got, vecs[6].expC);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_in_hold_flags", CB'({in_ready, out_valid, busy}), CB'(0));
    checkOutput("reset_in_hold_out_c", out_c, '0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    start = 1'b1;
    k_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_a = beatA(b, 5);
      in_b = Row1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_in_feed_flags", CB'({in_ready, out_valid, busy}), CB'(0));
    checkOutput("reset_in_feed_out_c", out_c, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(vecs[1], lat, got);
    checkOutput("post_reset_latency", CB'(lat), CB'(vecs[1].expLat));
    checkOutput("post_reset_out_c", got, vecs[1].expC);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
